lc3_prog_loader: RTL

Loads a flat LC-3 program image into word-addressed memory. The image uses the LC-3 object layout: word 0 holds the `.ORIG` address, and words 1..N-1 are the program. The block sits between the program-image source (the same flattened `{word[N-1], …, word[0]}` vector the cpu consumes, word 0 in bits [15:0]) and the memory write port. It writes each program word to consecutive addresses starting at the origin, then reports the entry PC to the cpu.

---
 rtl/lc3_pkg.sv | 30 +++
 rtl/lc3_image_mux.sv | 37 +++
 rtl/lc3_prog_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// ============================================================================
// Module  : lc3_pkg
// Brief   : Shared LC-3 widths, loader state encoding and flat-image helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3_pkg;

  localparam int LC3_WORD_W = 16;
  localparam int LC3_ADDR_W = 16;
  // Widest flat image the helper accepts; callers zero-extend to this width.
  localparam int LC3_IMG_MAX_W = LC3_WORD_W * 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

  function automatic logic [LC3_WORD_W-1:0] lc3_image_word(
    input logic [LC3_IMG_MAX_W-1:0] img,
    input int unsigned              i
  );
    return img[i*LC3_WORD_W +: LC3_WORD_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_image_mux.sv
// ============================================================================
// Module  : lc3_image_mux
// Brief   : Selects one 16-bit word of a captured flat image by index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_image_mux
  import lc3_pkg::*;
#(
  parameter int SIZE = 80,
  parameter int IDX_W = 4
) (
  input  logic [SIZE-1:0]       i_image,
  input  logic [IDX_W-1:0]      i_idx,
  output logic [LC3_WORD_W-1:0] o_word
);

  localparam int N = SIZE / LC3_WORD_W;

  logic [LC3_WORD_W-1:0] w_words [N];

  for (genvar g = 0; g < N; g++) begin : g_words
    assign w_words[g] = i_image[g*LC3_WORD_W +: LC3_WORD_W];
  end

  // Indices at or past N select zero rather than reading outside the image.
  always_comb begin
    o_word = '0;
    for (int i = 0; i < N; i++) begin
      if (i_idx == IDX_W'(i)) o_word = w_words[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/lc3_prog_loader.sv
// ============================================================================
// Module  : lc3_prog_loader
// Brief   : Writes an LC-3 object image (word 0 = origin) into memory and
//           reports the entry PC. Optional checksum: LC3_LOADER_CHECKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_prog_loader
  import lc3_pkg::*;
#(
  parameter int SIZE   = 80,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   prog,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pc_start
`ifdef LC3_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int N = SIZE / LC3_WORD_W;
  localparam int IDX_W = $clog2(N) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam bit SINGLE_WORD = (N == 1);

  loader_state_t         r_state;
  logic [SIZE-1:0]       r_image;
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_W-1:0]     r_addr;
  logic [15:0]           r_origin;
  logic                  r_mem_we;
  logic                  r_busy;
  logic                  r_done;
  logic [15:0]           r_pc_start;
  logic [15:0]           r_checksum;

  logic [LC3_IMG_MAX_W-1:0] w_prog_ext;
  logic [15:0]              w_origin_in;
  logic [15:0]              w_word;

  assign w_prog_ext  = LC3_IMG_MAX_W'(prog);
  assign w_origin_in = lc3_image_word(w_prog_ext, 0);

  lc3_image_mux #(
    .SIZE  (SIZE),
    .IDX_W (IDX_W)
  ) u_image_mux (
    .i_image (r_image),
    .i_idx   (r_idx),
    .o_word  (w_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_image    <= '0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_origin   <= '0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pc_start <= '0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_image    <= prog;
            r_origin   <= w_origin_in;
            r_addr     <= ADDR_W'(w_origin_in);
            r_idx      <= IDX_W'(1);
            r_checksum <= '0;
            if (SINGLE_WORD) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_pc_start <= w_origin_in;
            end else begin
              r_state  <= ST_LOAD;
              r_mem_we <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (mem_ready) begin
            r_checksum <= r_checksum + w_word;
            if (r_idx == LAST_IDX) begin
              r_state    <= ST_DONE;
              r_mem_we   <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_pc_start <= r_origin;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
              r_idx  <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_we <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  // Write data comes from the captured image, so prog may change freely mid-load.
  assign mem_addr = r_addr;
  assign mem_data = w_word;
  assign mem_we   = r_mem_we;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pc_start = r_pc_start;
`ifdef LC3_LOADER_CHECKSUM_EN
  assign checksum = r_checksum;
`endif

endmodule

`default_nettype wire
